// File: rtl/dsp_frame_pkg.sv
// rtl/dsp_frame_pkg.sv - shared offsets, bit indices and state encoding for the frame sequencer
package dsp_frame_pkg;

  localparam logic [2:0] OFF_CTRL    = 3'd0,
                         OFF_DECIM   = 3'd1,
                         OFF_LEN_L   = 3'd2,
                         OFF_LEN_H   = 3'd3,
                         OFF_STATUS  = 3'd4,
                         OFF_FRM_CNT = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IGN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } frame_state_t;

  // Returns {hit, offset}; the 9-bit subtraction makes addresses below base miss.
  function automatic logic [3:0] reg_decode(input logic [21:0] addr,
                                            input logic [5:0]  dev,
                                            input logic [7:0]  base);
    logic [8:0] rel;
    rel = {1'b0, addr[7:0]} - {1'b0, base};
    return {(addr[21:16] == dev) && (addr[15:8] == 8'h00) && (rel < 9'd6), rel[2:0]};
  endfunction

endpackage

// File: rtl/dsp_frame_if.sv
// rtl/dsp_frame_if.sv - fx register bus plus AD input and sample-memory output streams
interface dsp_frame_if;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic [15:0] ad_data;
  logic        ad_vld;
  logic [15:0] sm_data;
  logic        sm_vld;
  logic        sm_sof;
  logic        sm_eof;

  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, ad_data, ad_vld,
    input  fx_q, sm_data, sm_vld, sm_sof, sm_eof
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, ad_data, ad_vld,
    output fx_q, sm_data, sm_vld, sm_sof, sm_eof
  );
endinterface

// File: rtl/dsp_frame_regs.sv
// rtl/dsp_frame_regs.sv - fx decode, register file, sticky status and command pulses
module dsp_frame_regs
  import dsp_frame_pkg::*;
#(
  parameter logic [7:0] REG_BASE = 8'h10,
  parameter int         LEN_W    = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [5:0]       dev_id,
  input  logic             fx_wr,
  input  logic [21:0]      fx_waddr,
  input  logic [7:0]       fx_data,
  input  logic             fx_rd,
  input  logic [21:0]      fx_raddr,
  output logic [7:0]       fx_q,
  input  logic             busy,
  input  logic             done_set,
  input  logic             done_clr,
  input  logic             ign_set,
  input  logic [7:0]       frm_cnt,
  output logic             start_pulse,
  output logic             abort_pulse,
  output logic             cont,
  output logic [7:0]       decim,
  output logic [LEN_W-1:0] len
);

  logic [3:0] wdec;
  logic [3:0] rdec;
  logic [7:0] len_l;
  logic [7:0] len_h;
  logic       done;
  logic       start_ign;
  logic       ctrl_wr;
  logic       status_rd;
  logic [7:0] rdata;

  assign wdec      = reg_decode(fx_waddr, dev_id, REG_BASE);
  assign rdec      = reg_decode(fx_raddr, dev_id, REG_BASE);
  assign ctrl_wr   = fx_wr && wdec[3] && (wdec[2:0] == OFF_CTRL);
  assign status_rd = fx_rd && rdec[3] && (rdec[2:0] == OFF_STATUS);

  // ABORT outranks START when both arrive in the same CTRL write.
  assign abort_pulse = ctrl_wr && fx_data[CTRL_ABORT];
  assign start_pulse = ctrl_wr && fx_data[CTRL_START] && !fx_data[CTRL_ABORT];
  assign len         = LEN_W'({len_h, len_l});

  always_comb begin
    rdata = 8'h00;
    case (rdec[2:0])
      OFF_DECIM:   rdata = decim;
      OFF_LEN_L:   rdata = len_l;
      OFF_LEN_H:   rdata = len_h;
      OFF_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
        rdata[STAT_IGN]  = start_ign;
      end
      OFF_FRM_CNT: rdata = frm_cnt;
      default:     rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cont      <= 1'b0;
      decim     <= 8'h00;
      len_l     <= 8'h00;
      len_h     <= 8'h00;
      done      <= 1'b0;
      start_ign <= 1'b0;
      fx_q      <= 8'h00;
    end else begin
      if (fx_wr && wdec[3]) begin
        case (wdec[2:0])
          OFF_CTRL:  cont  <= fx_data[CTRL_CONT];
          OFF_DECIM: decim <= fx_data;
          OFF_LEN_L: len_l <= fx_data;
          OFF_LEN_H: len_h <= fx_data;
          default:   ;
        endcase
      end
      if (done_set)
        done <= 1'b0 | 1'b1;
      else if (done_clr)
        done <= 1'b0;
      // A new ignored START in the same cycle as the clearing read survives.
      if (ign_set)
        start_ign <= 1'b1;
      else if (status_rd)
        start_ign <= 1'b0;
      fx_q <= (fx_rd && rdec[3]) ? rdata : 8'h00;
    end
  end

endmodule

// File: rtl/dsp_frame_ctrl.sv
// rtl/dsp_frame_ctrl.sv - gates, decimates and frames the AD stream toward sample memory
module dsp_frame_ctrl
  import dsp_frame_pkg::*;
#(
  parameter logic [7:0] REG_BASE = 8'h10,
  parameter int         LEN_W    = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [5:0]  dev_id,
  dsp_frame_if.slave  bus,
  output logic        busy
);

  frame_state_t     state;
  logic [7:0]       dcnt;
  logic [LEN_W-1:0] scnt;
  logic [LEN_W-1:0] len_s;
  logic [7:0]       decim_s;
  logic [7:0]       frm_cnt;
  logic [15:0]      sm_data_q;
  logic             sm_vld_q;
  logic             sm_sof_q;
  logic             sm_eof_q;

  logic             start_pulse;
  logic             abort_pulse;
  logic             cont;
  logic [7:0]       decim;
  logic [LEN_W-1:0] len;
  logic [7:0]       fx_q;
  logic             last_s;
  logic             fwd;
  logic             reload;
  logic             done_set;
  logic             done_clr;
  logic             ign_set;

  dsp_frame_regs #(
    .REG_BASE (REG_BASE),
    .LEN_W    (LEN_W)
  ) u_regs (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .dev_id      (dev_id),
    .fx_wr       (bus.fx_wr),
    .fx_waddr    (bus.fx_waddr),
    .fx_data     (bus.fx_data),
    .fx_rd       (bus.fx_rd),
    .fx_raddr    (bus.fx_raddr),
    .fx_q        (fx_q),
    .busy        (busy),
    .done_set    (done_set),
    .done_clr    (done_clr),
    .ign_set     (ign_set),
    .frm_cnt     (frm_cnt),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse),
    .cont        (cont),
    .decim       (decim),
    .len         (len)
  );

  assign busy        = (state == ST_RUN);
  assign bus.fx_q    = fx_q;
  assign bus.sm_data = sm_data_q;
  assign bus.sm_vld  = sm_vld_q;
  assign bus.sm_sof  = sm_sof_q;
  assign bus.sm_eof  = sm_eof_q;

  // Sticky-bit events are combinational so STATUS reflects them on the very next read.
  assign last_s   = (scnt == len_s - LEN_W'(1));
  assign fwd      = (state == ST_RUN) && bus.ad_vld && (dcnt == 8'd0) && !abort_pulse;
  assign reload   = cont && (len != '0);
  assign done_set = fwd && last_s && !reload;
  assign done_clr = start_pulse && (state == ST_IDLE);
  assign ign_set  = start_pulse && ((state == ST_RUN) || (len == '0));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dcnt      <= 8'd0;
      scnt      <= '0;
      len_s     <= '0;
      decim_s   <= 8'd0;
      frm_cnt   <= 8'd0;
      sm_data_q <= 16'h0000;
      sm_vld_q  <= 1'b0;
      sm_sof_q  <= 1'b0;
      sm_eof_q  <= 1'b0;
    end else begin
      sm_vld_q <= 1'b0;
      sm_sof_q <= 1'b0;
      sm_eof_q <= 1'b0;
      if (abort_pulse) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_pulse && (len != '0)) begin
              state   <= ST_RUN;
              len_s   <= len;
              decim_s <= decim;
              scnt    <= '0;
              dcnt    <= 8'd0;
            end
          end
          ST_RUN: begin
            if (bus.ad_vld) begin
              if (dcnt != 8'd0) begin
                dcnt <= dcnt - 8'd1;
              end else begin
                sm_data_q <= bus.ad_data;
                sm_vld_q  <= 1'b1;
                sm_sof_q  <= (scnt == '0);
                sm_eof_q  <= last_s;
                if (!last_s) begin
                  scnt <= scnt + LEN_W'(1);
                  dcnt <= decim_s;
                end else begin
                  // Frame boundary: counters restart and shadows pick up pending writes.
                  frm_cnt <= frm_cnt + 8'd1;
                  scnt    <= '0;
                  dcnt    <= 8'd0;
                  if (reload) begin
                    len_s   <= len;
                    decim_s <= decim;
                  end else begin
                    state <= ST_IDLE;
                  end
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_frame_ctrl.sv
// tb/tb_dsp_frame_ctrl.sv - table-driven and directed checks for dsp_frame_ctrl
module tb_dsp_frame_ctrl;

  localparam logic [7:0] REG_BASE = 8'h10;
  localparam logic [5:0] DEV      = 6'h2A;
  localparam logic [5:0] OTHER    = 6'h15;

  localparam logic [2:0] R_CTRL = 3'd0, R_DECIM = 3'd1, R_LEN_L = 3'd2,
                         R_LEN_H = 3'd3, R_STATUS = 3'd4, R_FRM = 3'd5;

  typedef struct {
    int wr; int wo; int wd;
    int rd; int ro;
    int av; int ad;
    int eq; int ev; int ed; int es; int ee; int eb;
  } vec_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic [5:0] dev_id = DEV;
  logic busy;
  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  dsp_frame_if bus ();

  dsp_frame_ctrl #(.REG_BASE(REG_BASE), .LEN_W(16)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .dev_id  (dev_id),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [21:0] addr(input logic [5:0] dev, input logic [7:0] mid, input logic [2:0] off);
    return {dev, mid, REG_BASE + {5'd0, off}};
  endfunction

  function automatic vec_t mk(input int wr, wo, wd, rd, ro, av, ad, eq, ev, ed, es, ee, eb);
    vec_t v;
    v.wr = wr; v.wo = wo; v.wd = wd; v.rd = rd; v.ro = ro; v.av = av; v.ad = ad;
    v.eq = eq; v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.fx_wr = 1'b0; bus.fx_waddr = '0; bus.fx_data = '0;
    bus.fx_rd = 1'b0; bus.fx_raddr = '0;
    bus.ad_vld = 1'b0; bus.ad_data = '0;
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] d,
                        input logic [5:0] dev = DEV, input logic [7:0] mid = 8'h00);
    bus.fx_wr = 1'b1; bus.fx_waddr = addr(dev, mid, off); bus.fx_data = d;
    @(negedge clk_sys);
    bus.fx_wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] off, input logic [7:0] exp, input string nm,
                        input logic [5:0] dev = DEV, input logic [7:0] mid = 8'h00);
    bus.fx_rd = 1'b1; bus.fx_raddr = addr(dev, mid, off);
    @(negedge clk_sys);
    chk(nm, 32'(bus.fx_q), 32'(exp));
    bus.fx_rd = 1'b0;
  endtask

  task automatic chk_out(input string nm, input int ev, input int ed, input int es, input int ee, input int eb);
    chk({nm, " vld"}, 32'(bus.sm_vld), ev);
    if (ev != 0) chk({nm, " data"}, 32'(bus.sm_data), ed);
    chk({nm, " sof"}, 32'(bus.sm_sof), es);
    chk({nm, " eof"}, 32'(bus.sm_eof), ee);
    chk({nm, " busy"}, 32'(busy), eb);
  endtask

  initial begin
    // LEN=4/DECIM=0 frame, then LEN=3/DECIM=2 frame; each row's expectations
    // are the outputs produced by the previous row's inputs.
    //              wr wo wd  rd ro  av ad   eq   ev ed  es ee eb
    tbl.push_back(mk(0, 0, 0,  1, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 1,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 2,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 3,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 4,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 5,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 2, 4,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 3, 0,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 1,  0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 2,  0,   1, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 3,  0,   1, 2,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 4,  0,   1, 3,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 5,  0,   1, 4,  0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 6,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 4,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 5,  0, 0,  2,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 2, 3,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 2,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0, 0,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 10, 0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 11, 0,   1, 10, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 12, 0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 13, 0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 14, 0,   1, 13, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 15, 0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 16, 0,   0, 0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 17, 0,   1, 16, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  1, 18, 0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 4,  0, 0,  0,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 5,  0, 0,  2,   0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  2,   0, 0,  0, 0, 0));

    idle_inputs();
    repeat (3) @(negedge clk_sys);
    chk("reset sm_vld", 32'(bus.sm_vld), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset fx_q", 32'(bus.fx_q), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      chk($sformatf("row%0d fx_q", i), 32'(bus.fx_q), v.eq);
      chk_out($sformatf("row%0d", i), v.ev, v.ed, v.es, v.ee, v.eb);
      bus.fx_wr = v.wr[0]; bus.fx_waddr = addr(DEV, 8'h00, v.wo[2:0]); bus.fx_data = v.wd[7:0];
      bus.fx_rd = v.rd[0]; bus.fx_raddr = addr(DEV, 8'h00, v.ro[2:0]);
      bus.ad_vld = v.av[0]; bus.ad_data = v.ad[15:0];
      @(negedge clk_sys);
    end
    idle_inputs();

    // Continuous LEN=2 frames, back-to-back samples, then ABORT.
    wr_reg(R_LEN_L, 8'd2);
    wr_reg(R_DECIM, 8'd0);
    wr_reg(R_CTRL, 8'h03);
    chk("cont start busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      bus.ad_vld = 1'b1; bus.ad_data = 16'h0100 + 16'(i);
      @(negedge clk_sys);
      chk_out($sformatf("cont s%0d", i), 1, 'h100 + i, (i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0, 1);
    end
    bus.ad_vld = 1'b0;
    rd_chk(R_FRM, 8'd5, "cont frm_cnt");
    wr_reg(R_CTRL, 8'h04);
    chk_out("abort", 0, 0, 0, 0, 0);
    bus.ad_vld = 1'b1; bus.ad_data = 16'h0BAD;
    @(negedge clk_sys);
    chk_out("after abort", 0, 0, 0, 0, 0);
    bus.ad_vld = 1'b0;
    rd_chk(R_STATUS, 8'h00, "abort status");
    rd_chk(R_FRM, 8'd5, "abort frm_cnt");

    // START with LEN=0 is ignored and the sticky flag clears on read.
    wr_reg(R_LEN_L, 8'd0);
    wr_reg(R_CTRL, 8'h01);
    chk("len0 busy", 32'(busy), 0);
    rd_chk(R_STATUS, 8'h04, "len0 status1");
    rd_chk(R_STATUS, 8'h00, "len0 status2");

    // LEN rewritten 2->5 mid-frame only takes effect on the next frame.
    wr_reg(R_LEN_L, 8'd2);
    wr_reg(R_CTRL, 8'h03);
    chk("rewr start busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) begin
      bus.ad_vld = 1'b1; bus.ad_data = 16'h0200 + 16'(i);
      if (i == 0) begin
        bus.fx_wr = 1'b1; bus.fx_waddr = addr(DEV, 8'h00, R_LEN_L); bus.fx_data = 8'd5;
      end
      @(negedge clk_sys);
      bus.fx_wr = 1'b0;
      chk_out($sformatf("rewr s%0d", i), 1, 'h200 + i, (i == 0 || i == 2) ? 1 : 0, (i == 1 || i == 6) ? 1 : 0, 1);
    end
    bus.ad_vld = 1'b0;
    wr_reg(R_CTRL, 8'h03);
    chk("start in run busy", 32'(busy), 1);
    wr_reg(R_CTRL, 8'h04);
    chk("rewr abort busy", 32'(busy), 0);
    rd_chk(R_STATUS, 8'h04, "start in run status");
    rd_chk(R_FRM, 8'd7, "rewr frm_cnt");

    // ABORT and START in one write: ABORT wins.
    wr_reg(R_CTRL, 8'h05);
    chk("abort+start busy", 32'(busy), 0);
    rd_chk(R_STATUS, 8'h00, "abort+start status");

    // Address qualification.
    wr_reg(R_DECIM, 8'd7, OTHER);
    rd_chk(R_DECIM, 8'd0, "foreign write");
    rd_chk(R_LEN_L, 8'd0, "foreign read", OTHER);
    rd_chk(R_LEN_L, 8'd5, "own read");
    rd_chk(R_LEN_L, 8'd0, "mid bits read", DEV, 8'h01);
    wr_reg(R_LEN_L, 8'd9, DEV, 8'h01);
    rd_chk(R_LEN_L, 8'd5, "mid bits write");

    // Reset asserted mid-frame clears at once and leaves no partial frame.
    wr_reg(R_LEN_L, 8'd4);
    wr_reg(R_CTRL, 8'h01);
    bus.ad_vld = 1'b1; bus.ad_data = 16'h0300;
    @(negedge clk_sys);
    chk_out("pre reset", 1, 'h300, 1, 0, 1);
    bus.ad_data = 16'h0301;
    rst_n = 1'b0;
    #1;
    chk_out("in reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ad_data = 16'h0302 + 16'(i);
      @(negedge clk_sys);
      chk_out($sformatf("post reset %0d", i), 0, 0, 0, 0, 0);
    end
    bus.ad_vld = 1'b0;
    rd_chk(R_FRM, 8'd0, "post reset frm_cnt");
    rd_chk(R_LEN_L, 8'd0, "post reset len_l");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
